// File: rtl/decoder_hold.sv
// Registered 3-to-8 one-hot decoder with valid/ready intake, programmable hold time
// and a wrapping count of accepted codes.
module decoder_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       In,
  input  logic             InValid,
  output logic             InReady,
  output logic [7:0]       Out,
  output logic             OutValid,
  output logic             Done,
  output logic [CNT_W-1:0] Count
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("decoder_hold: HOLD_CYCLES must be in 1..255");
  end

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [7:0] HoldInit = 8'(HOLD_CYCLES - 1);

  state_e           state_q;
  logic [7:0]       hold_q;
  logic [7:0]       out_q;
  logic [CNT_W-1:0] count_q;
  logic             accept;

  // Ready comes from registers only; hold_q is zero while idle.
  assign InReady  = (state_q == StIdle) || (hold_q == 8'd0);
  assign accept   = InValid && InReady;
  assign Out      = out_q;
  assign OutValid = (state_q == StHold);
  assign Done     = (state_q == StHold) && (hold_q == 8'd0);
  assign Count    = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= 8'd0;
      out_q   <= 8'h00;
      count_q <= '0;
    end else if (accept) begin
      // Also covers chaining from the last hold cycle with no idle gap.
      state_q <= StHold;
      out_q   <= 8'h01 << In;
      hold_q  <= HoldInit;
      count_q <= count_q + CNT_W'(1);
    end else if (state_q == StHold) begin
      if (hold_q != 8'd0) begin
        hold_q <= hold_q - 8'd1;
      end else begin
        state_q <= StIdle;
        out_q   <= 8'h00;
      end
    end
  end

endmodule

// File: doc/decoder_hold.md
Name: decoder_hold

Overview:
- Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time.
- Takes a 3-bit index from an upstream producer, for example the 8-to-3 encoder output with its Valid.
- Drives the matching one-hot line for exactly HOLD_CYCLES clocks, then releases it or chains directly into the next index.
- Keeps a running count of accepted codes for debug and status.

Parameters:
- HOLD_CYCLES, 4, number of clocks each decoded one-hot value is held; legal range 1 to 255.
- CNT_W, 8, width of the accepted-code counter Count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- In  input  3  binary index to decode; sampled only on accept.
- InValid  input  1  In holds a valid index.
- InReady  output  1  block can accept In this cycle.
- Out  output  8  registered one-hot decode; all zeros when idle.
- OutValid  output  1  Out is driving a decoded value.
- Done  output  1  high during the last hold cycle of the current value.
- Count  output  CNT_W  number of accepted codes; wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low regardless of clk:
  - State IDLE, hold counter 0.
  - Out 8'h00, OutValid 0, Done 0, Count 0, InReady 1.
- States:
  - IDLE: Out = 0.
  - HOLD: Out is one-hot; the hold counter holds the remaining cycles minus 1.
- Accept:
  - An accept is a rising edge with InValid && InReady.
  - On accept, Out is loaded with 1 << In, and the hold counter is loaded with HOLD_CYCLES-1.
  - The state goes to HOLD and Count increments.
  - Latency: Out and OutValid are valid in the cycle after the accept edge.
- InReady = (state == IDLE) || (hold counter == 0).
  - It depends only on registered state, never combinationally on InValid or In.
- In HOLD with counter > 0: the counter decrements each cycle, and Out is unchanged.
- Done = OutValid && (hold counter == 0). It is a function of registers only.
- Last hold cycle (counter == 0):
  - Accept in that cycle: the new one-hot value is loaded with no idle gap, the counter reloads, and the state stays HOLD.
  - No accept: go to IDLE next cycle, with Out = 0 and OutValid = 0.
- HOLD_CYCLES = 1:
  - InReady is constantly 1 after reset.
  - Each accepted code is held one cycle, and Done is high in every HOLD cycle.
- In and InValid changes during non-final hold cycles are ignored. In is don't-care (X-tolerant) when InValid = 0.
- Count is CNT_W bits and increments by 1 per accept, wrapping from 2^CNT_W-1 to 0. There is no saturation.
- Invariants, checkable every cycle:
  - Out is 0 or exactly one-hot.
  - OutValid == |Out.
  - Out is never changed outside an accept or the transition to IDLE.
- Reset mid-hold: the current value is dropped with no Done pulse, and the count is lost. The first cycle after reset release behaves as IDLE.
- No combinational path from any input to any output.

Test Plan:
- Reset, then In = 3'd5 with InValid for one cycle (HOLD_CYCLES = 4):
  - Out = 8'b0010_0000 and OutValid = 1 for exactly 4 cycles starting the next cycle.
  - Done is high in the 4th cycle only; InReady is low in hold cycles 1-3.
  - Then Out = 0 and Count = 1.
- InValid held 1 while In steps 0..7 on each accept:
  - Out = 8'h01, 8'h02, ..., 8'h80, each held 4 cycles, 32 consecutive OutValid cycles with no gaps.
  - Done every 4th cycle; Count = 8.
- Accept In = 3'd1, then assert In = 3'd2 with InValid from hold cycle 1:
  - 8'h02 is held 4 cycles, then 8'h04 starts immediately with no gap.
  - The In = 2 value is not accepted before the last hold cycle.
- rst_n pulsed low during hold cycle 2 of In = 3'd7:
  - Out = 0, OutValid = 0, Done = 0, Count = 0, InReady = 1 asynchronously, before the next clk edge.
  - After release, the next accept decodes normally.
- HOLD_CYCLES = 1, stream In = 0..7 back-to-back:
  - Out changes every cycle through 8'h01..8'h80; Done = 1 and InReady = 1 throughout; Count = 8.
- CNT_W = 8, 257 accepts with HOLD_CYCLES = 1:
  - Count reads 255 after 255 accepts, 0 after 256, and 1 after 257.
